// File: rtl/mem_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_master_pkg
// Shared definitions for the memory bus initiator: the sequencer state
// encoding, the memory cell width and the little-endian byte-lane indices
// (lane 0 = low byte at the base address, lane 1 = high byte at base + 1).
// -----------------------------------------------------------------------------
package mem_master_pkg;

    localparam int BYTE_W = 8;

    // Byte index values; a word lives at {addr + LANE_HI, addr + LANE_LO}.
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WR,
        ST_RD,
        ST_CAP,
        ST_RSP
    } state_e;

endpackage

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
// Bus initiator for the 8-bit-cell memory. Accepts byte / 16-bit word read
// and write requests on a valid/ready handshake and sequences the memory's
// addr_en / in_en / out_en strobes, one byte per address-latch cycle.
// Words are little-endian. Completion is a one-cycle rsp_valid pulse.
//
// Ports
//   clk, rst                 : clock, synchronous active-low reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_we, req_word         : write / word-size qualifiers
//   req_addr, req_wdata      : byte address of low byte, write data
//   rsp_valid, rsp_rdata     : completion pulse, read data (0 for writes)
//   mem_addr_en, mem_addr    : memory address latch
//   mem_in_en, mem_in        : memory write strobe and zero-extended byte
//   mem_out_en, mem_out      : memory read strobe and registered read data
// -----------------------------------------------------------------------------
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_addr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_in_en,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_out_en,
    input  logic [DATA_W-1:0] mem_out
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic              word_q, word_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_in_q, mem_in_d;
    logic              last_byte;
    logic [BYTE_W-1:0] wr_byte;

    // The memory's upper read lane carries nothing meaningful for byte cells.
    logic unused_mem_out_hi;
    assign unused_mem_out_hi = ^mem_out[DATA_W-1:BYTE_W];

    // A byte access ends after lane 0, a word access after lane 1.
    assign last_byte = (idx_q == word_q);
    assign wr_byte   = (idx_q == LANE_HI) ? wdata_q[2*BYTE_W-1:BYTE_W]
                                          : wdata_q[BYTE_W-1:0];

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        word_d     = word_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_in_d   = mem_in_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    word_d     = req_word;
                    base_d     = req_addr;
                    wdata_d    = req_wdata;
                    idx_d      = LANE_LO;
                    rdata_d    = '0;
                    // Address for the first ADDR cycle is registered here so
                    // that mem_addr is a flop output, not a path from req_addr.
                    mem_addr_d = req_addr;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (we_q) begin
                    mem_in_d = {{(DATA_W-BYTE_W){1'b0}}, wr_byte};
                    state_d  = ST_WR;
                end else begin
                    state_d  = ST_RD;
                end
            end
            ST_WR: begin
                if (last_byte) begin
                    state_d = ST_RSP;
                end else begin
                    idx_d      = LANE_HI;
                    // Modulo add: a word at the top address wraps to 0.
                    mem_addr_d = base_q + ADDR_W'(1);
                    state_d    = ST_ADDR;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                if (idx_q == LANE_HI) begin
                    rdata_d[2*BYTE_W-1:BYTE_W] = mem_out[BYTE_W-1:0];
                end else begin
                    rdata_d[BYTE_W-1:0] = mem_out[BYTE_W-1:0];
                end
                if (last_byte) begin
                    state_d = ST_RSP;
                end else begin
                    idx_d      = LANE_HI;
                    mem_addr_d = base_q + ADDR_W'(1);
                    state_d    = ST_ADDR;
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= LANE_LO;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
        end
    end

    // Request capture registers only matter once the FSM leaves IDLE.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        word_q  <= word_d;
        base_q  <= base_d;
        wdata_q <= wdata_d;
    end

    // Strobes are decoded from the state, so they are mutually exclusive.
    assign mem_addr_en = (state_q == ST_ADDR);
    assign mem_in_en   = (state_q == ST_WR);
    assign mem_out_en  = (state_q == ST_RD);
    assign rsp_valid   = (state_q == ST_RSP);
    assign req_ready   = (state_q == ST_IDLE) && rst;
    assign mem_addr    = mem_addr_q;
    assign mem_in      = mem_in_q;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_word;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_in_en;
    logic [15:0] mem_in;
    logic        mem_out_en;
    logic [15:0] mem_out;

    always #5 clk = ~clk;

    mem_master #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_word    (req_word),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_addr_en (mem_addr_en),
        .mem_addr    (mem_addr),
        .mem_in_en   (mem_in_en),
        .mem_in      (mem_in),
        .mem_out_en  (mem_out_en),
        .mem_out     (mem_out)
    );

    // Behavioural 8-bit-cell memory with a registered read port.
    logic [7:0]  tbmem [0:65535];
    logic [15:0] lat_addr;
    logic [7:0]  mem_hi;

    always @(posedge clk) begin
        if (mem_addr_en) lat_addr <= mem_addr;
        if (mem_in_en)   tbmem[lat_addr] <= mem_in[7:0];
        if (mem_out_en)  mem_out <= {mem_hi, tbmem[lat_addr]};
    end

    typedef struct packed {
        logic [15:0] rdata;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb[$];
    int          acc_q[$];
    logic [15:0] addr_log[$];
    int          cyc = 0;
    int          rsp_count = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept-edge bookkeeping for latency measurement.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) acc_q.delete();
        else if (req_valid && req_ready) acc_q.push_back(cyc);
    end

    // Response scoreboard and bus-protocol monitor.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (mem_addr_en) addr_log.push_back(mem_addr);
        if (mem_addr_en || mem_in_en || mem_out_en)
            check("one_enable", $countones({mem_addr_en, mem_in_en, mem_out_en}), 1);
        if (rsp_valid) begin
            rsp_count++;
            check("rsp_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("accept_seen", acc_q.size() > 0, 1);
                if (acc_q.size() > 0) begin
                    a = acc_q.pop_front();
                    check("latency", cyc - a + 1, e.lat);
                end
            end
        end
    end

    task automatic send(input logic we, input logic word, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input int lat, input bit expect_rsp, input bit drop);
        bit ok;
        req_we    = we;
        req_word  = word;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        if (expect_rsp) sb.push_back('{rdata: exp_rd, lat: lat});
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accepted", ok, 1);
        @(posedge clk);
        #1;
        if (drop) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] before31;
        int         rsp_before;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_word  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_hi    = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_enables", {mem_addr_en, mem_in_en, mem_out_en}, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_in", mem_in, 16'h0000);
        check("rst_rdata", rsp_rdata, 16'h0000);
        rst = 1'b1;
        #1;
        check("ready_after_rst", req_ready, 1);

        // Byte write then byte read
        send(1'b1, 1'b0, 16'h0010, 16'h00A5, 16'h0000, 3, 1'b1, 1'b1);
        drain();
        check("mem_10", tbmem[16'h0010], 8'hA5);
        send(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00A5, 4, 1'b1, 1'b1);
        drain();

        // Word write then word read
        send(1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 5, 1'b1, 1'b1);
        drain();
        check("mem_20", tbmem[16'h0020], 8'hEF);
        check("mem_21", tbmem[16'h0021], 8'hBE);
        send(1'b0, 1'b1, 16'h0020, 16'h0000, 16'hBEEF, 7, 1'b1, 1'b1);
        drain();

        // Word write across the top of the address space
        addr_log.delete();
        send(1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 5, 1'b1, 1'b1);
        drain();
        check("wrap_addr_count", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("wrap_addr0", addr_log[0], 16'hFFFF);
            check("wrap_addr1", addr_log[1], 16'h0000);
        end
        check("mem_ffff", tbmem[16'hFFFF], 8'h34);
        check("mem_0000", tbmem[16'h0000], 8'h12);

        // Reset in the second ADDR cycle of a word write
        before31 = tbmem[16'h0031];
        send(1'b1, 1'b1, 16'h0030, 16'h5566, 16'h0000, 5, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("abort_wr_phase", mem_in_en, 1);
        @(posedge clk);
        #1;
        check("abort_addr2_en", mem_addr_en, 1);
        check("abort_addr2", mem_addr, 16'h0031);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_enables", {mem_addr_en, mem_in_en, mem_out_en}, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_ready_low", req_ready, 0);
        check("abort_mem_addr", mem_addr, 16'h0000);
        check("abort_mem_in", mem_in, 16'h0000);
        rst = 1'b1;
        #1;
        check("abort_ready_high", req_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_mem_30", tbmem[16'h0030], 8'h66);
        check("abort_mem_31", tbmem[16'h0031], before31);

        // req_valid held high across three mixed requests
        mem_hi     = 8'hFF;
        rsp_before = rsp_count;
        send(1'b1, 1'b1, 16'h0040, 16'h1357, 16'h0000, 5, 1'b1, 1'b0);
        send(1'b0, 1'b0, 16'h0041, 16'h0000, 16'h0013, 4, 1'b1, 1'b0);
        send(1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1357, 7, 1'b1, 1'b1);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("held_rsp_count", rsp_count - rsp_before, 3);
        check("held_accepts_left", acc_q.size(), 0);

        // Byte read with the memory's upper lane driven high
        send(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h00EF, 4, 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
